// File: rtl/call_stack_if.sv
// Push/pop subroutine interface between control_module (master) and the
// return-address stack (slave).
//   push, pop      : request a store / removal of the top entry this cycle
//   push_addr      : return address to store on push
//   clr_err        : clears the sticky overflow/underflow flags
//   top_addr       : current top entry, 0 when empty
//   level          : number of valid entries
//   empty, full    : level == 0 / level == DEPTH
//   overflow       : sticky, push attempted while full
//   underflow      : sticky, pop attempted while empty
interface call_stack_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int PTR_WIDTH  = $clog2(DEPTH + 1)
);
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] push_addr;
    logic                  clr_err;
    logic [ADDR_WIDTH-1:0] top_addr;
    logic [PTR_WIDTH-1:0]  level;
    logic                  empty;
    logic                  full;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output push, pop, push_addr, clr_err,
        input  top_addr, level, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, push_addr, clr_err,
        output top_addr, level, empty, full, overflow, underflow
    );
endinterface

// File: rtl/call_stack.sv
// Return-address stack responding to control_module's push/pop interface.
// CALL pushes a return address; RET samples top_addr in the same cycle it
// pops (zero-latency read). Reports full/empty and sticky error flags.
// Ports:
//   clk  : system clock, all state changes on the rising edge
//   rst  : synchronous active-high reset (clears sp and error flags)
//   bus  : call_stack_if slave modport (see interface header)
module call_stack #(
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 8
) (
    input  logic         clk,
    input  logic         rst,
    call_stack_if.slave  bus
);
    localparam int PTR_WIDTH = $clog2(DEPTH + 1);
    localparam int IDX_WIDTH = $clog2(DEPTH);

    logic [ADDR_WIDTH-1:0] mem [DEPTH];
    logic [PTR_WIDTH-1:0]  sp;           // first free slot == level
    logic                  overflow;
    logic                  underflow;

    logic                  empty;
    logic                  full;
    logic                  replace;
    logic                  do_push;
    logic                  do_pop;
    logic                  ovf_set;
    logic                  unf_set;
    logic [IDX_WIDTH-1:0]  top_idx;
    logic [IDX_WIDTH-1:0]  wr_idx;

    assign empty   = (sp == '0);
    assign full    = (sp == PTR_WIDTH'(DEPTH));

    // push&pop on a non-empty stack overwrites the top in place, even when
    // full. On an empty stack it degrades to a plain push (plus underflow).
    assign replace = bus.push && bus.pop && !empty;
    assign do_push = bus.push && !replace && !full;
    assign do_pop  = bus.pop && !bus.push && !empty;
    assign ovf_set = bus.push && !bus.pop && full;
    assign unf_set = bus.pop && empty;

    // Indices are only used when in range: top_idx when !empty, wr_idx for
    // a push when !full or a replace when !empty.
    assign top_idx = IDX_WIDTH'(sp - PTR_WIDTH'(1));
    assign wr_idx  = replace ? top_idx : IDX_WIDTH'(sp);

    always_ff @(posedge clk) begin
        if (rst) begin
            sp        <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (do_push) begin
                sp <= sp + PTR_WIDTH'(1);
            end else if (do_pop) begin
                sp <= sp - PTR_WIDTH'(1);
            end
            // A new error in the same cycle as clr_err keeps the flag set.
            overflow  <= ovf_set || (overflow  && !bus.clr_err);
            underflow <= unf_set || (underflow && !bus.clr_err);
        end
    end

    // Storage is not reset; entries below sp are always written before read.
    always_ff @(posedge clk) begin
        if (!rst && (do_push || replace)) begin
            mem[wr_idx] <= bus.push_addr;
        end
    end

    assign bus.top_addr  = empty ? '0 : mem[top_idx];
    assign bus.level     = sp;
    assign bus.empty     = empty;
    assign bus.full      = full;
    assign bus.overflow  = overflow;
    assign bus.underflow = underflow;
endmodule
